// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Owns the program counter and sequences a combinational instruction
//   memory. Each instruction is fetched in one cycle (FETCH), held in the
//   instruction register, and offered to the execute stage over a valid/ready
//   handshake (ISSUE). Execute may redirect the PC at any time during FETCH or
//   ISSUE. Accepting the HALT opcode stops sequencing until start is raised
//   again.
//
// Ports:
//   clk             in   1  system clock, rising-edge active
//   reset           in   1  asynchronous, active-high reset
//   start           in   1  level; leaves IDLE/HALTED and begins fetching
//   pc_address      out  8  address to instruction memory (PC register)
//   mem_data        in   8  instruction memory read data, same-cycle
//   instr_out       out  8  issued instruction (instruction register)
//   instr_pc        out  8  address the issued instruction came from
//   instr_valid     out  1  instr_out/instr_pc offered to execute
//   instr_ready     in   1  execute accepts the offered instruction
//   redirect_valid  in   1  execute requests a PC change
//   redirect_addr   in   8  new PC when redirect_valid=1
//   halted          out  1  HALT opcode accepted, sequencing stopped
//   busy            out  1  high in FETCH or ISSUE
//   issue_count     out  8  number of accepted instructions, wrapping
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] PC_STEP     = 8'd2,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] pc_address,
  input  logic [7:0] mem_data,
  output logic [7:0] instr_out,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr,
  output logic       halted,
  output logic       busy,
  output logic [7:0] issue_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic [7:0] r_instr_pc;
  logic [7:0] r_issue_count;

  logic       w_instr_valid;
  logic       w_handshake;

  // A redirect in ISSUE squashes the offer in the same cycle, so execute
  // never sees a handshake on an instruction it is branching away from.
  assign w_instr_valid = (r_state == S_ISSUE) && !redirect_valid;
  assign w_handshake   = w_instr_valid && instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= 8'h00;
      r_instr_pc    <= 8'h00;
      r_issue_count <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect_valid) begin
            // Refetch from the new target; IR keeps its old contents.
            r_pc <= redirect_addr;
          end else begin
            r_ir       <= mem_data;
            r_instr_pc <= r_pc;
            r_pc       <= r_pc + PC_STEP;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (redirect_valid) begin
            r_pc    <= redirect_addr;
            r_state <= S_FETCH;
          end else if (w_handshake) begin
            r_issue_count <= r_issue_count + 8'd1;
            r_state       <= (r_ir == HALT_OPCODE) ? S_HALTED : S_FETCH;
          end
        end
        S_HALTED: begin
          // PC already points past the HALT, so start resumes there.
          if (start) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc_address  = r_pc;
  assign instr_out   = r_ir;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = w_instr_valid;
  assign halted      = (r_state == S_HALTED);
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign issue_count = r_issue_count;

endmodule
